generation_sequencer: RTL and testbench

Top-level controller for the Game-of-Life next-state datapath. It starts each generation on a video frame boundary and steps `calc_row` through every row of the board. For each row it issues one request to the line buffer and waits for that row's write-back to complete. At the end of a generation it swaps the BRAM ping-pong bank and counts generations. It replaces the free-running row counter in the top level and supports run, single-step and mode-change abort.

---
 rtl/generation_sequencer.sv | 129 ++++++++++++
 tb/tb_generation_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/generation_sequencer.sv
// rtl/generation_sequencer.sv - per-generation row sequencer with bank swap, watchdog and mode abort
module generation_sequencer #(
    parameter int ROWS    = 720,
    parameter int ROW_W   = 10,
    parameter int GEN_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             out_stream_aclk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             mode,
    input  logic             frame_start,
    input  logic             row_done,
    output logic             calc_flag,
    output logic [ROW_W-1:0] calc_row,
    output logic             bank_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             gen_done,
    output logic             busy,
    output logic             err
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ISSUE,
        WAIT_ROW,
        SWAP
    } state_t;

    state_t           state_q;
    logic             mode_q;
    logic [WD_W-1:0]  wdog_q;
    logic             calc_flag_q;
    logic [ROW_W-1:0] calc_row_q;
    logic             bank_sel_q;
    logic [GEN_W-1:0] gen_count_q;
    logic             gen_done_q;
    logic             busy_q;
    logic             err_q;

    // Outputs are registered and set on the transition into the state they belong to.
    always_ff @(posedge out_stream_aclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            wdog_q      <= '0;
            calc_flag_q <= 1'b0;
            calc_row_q  <= '0;
            bank_sel_q  <= 1'b0;
            gen_count_q <= '0;
            gen_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode;
            calc_flag_q <= 1'b0;
            gen_done_q  <= 1'b0;
            if (mode != mode_q) begin
                state_q    <= IDLE;
                calc_row_q <= '0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!err_q && (run || step)) begin
                            state_q <= WAIT_FRAME;
                            busy_q  <= 1'b1;
                        end
                    end
                    WAIT_FRAME: begin
                        if (frame_start) begin
                            state_q     <= ISSUE;
                            calc_row_q  <= '0;
                            calc_flag_q <= 1'b1;
                        end
                    end
                    ISSUE: begin
                        state_q <= WAIT_ROW;
                        wdog_q  <= '0;
                    end
                    WAIT_ROW: begin
                        if (row_done) begin
                            if (calc_row_q == LAST_ROW) begin
                                state_q    <= SWAP;
                                gen_done_q <= 1'b1;
                            end else begin
                                state_q     <= ISSUE;
                                calc_row_q  <= calc_row_q + 1'b1;
                                calc_flag_q <= 1'b1;
                            end
                        end else if (wdog_q == WD_LIMIT) begin
                            state_q    <= IDLE;
                            err_q      <= 1'b1;
                            calc_row_q <= '0;
                            busy_q     <= 1'b0;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    SWAP: begin
                        state_q     <= IDLE;
                        bank_sel_q  <= ~bank_sel_q;
                        gen_count_q <= gen_count_q + 1'b1;
                        calc_row_q  <= '0;
                        busy_q      <= 1'b0;
                    end
                    default: begin
                        state_q    <= IDLE;
                        calc_row_q <= '0;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign calc_flag = calc_flag_q;
    assign calc_row  = calc_row_q;
    assign bank_sel  = bank_sel_q;
    assign gen_count = gen_count_q;
    assign gen_done  = gen_done_q;
    assign busy      = busy_q;
    assign err       = err_q;
endmodule

// File: tb/tb_generation_sequencer.sv
// tb/tb_generation_sequencer.sv - randomized self-checking bench for generation_sequencer
module tb_generation_sequencer;
    localparam int ROWS    = 4;
    localparam int ROW_W   = 3;
    localparam int GEN_W   = 2;
    localparam int TIMEOUT = 8;
    localparam int GEN_MOD = 1 << GEN_W;

    logic             clk = 1'b0;
    logic             rst, run, step, mode, frame_start, row_done;
    logic             calc_flag;
    logic [ROW_W-1:0] calc_row;
    logic             bank_sel;
    logic [GEN_W-1:0] gen_count;
    logic             gen_done, busy, err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_gens   = 0;

    always #5 clk = ~clk;

    generation_sequencer #(
        .ROWS(ROWS), .ROW_W(ROW_W), .GEN_W(GEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .out_stream_aclk(clk),
        .rst(rst),
        .run(run),
        .step(step),
        .mode(mode),
        .frame_start(frame_start),
        .row_done(row_done),
        .calc_flag(calc_flag),
        .calc_row(calc_row),
        .bank_sel(bank_sel),
        .gen_count(gen_count),
        .gen_done(gen_done),
        .busy(busy),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic check_totals;
        check("gen_count", gen_count, n_gens % GEN_MOD);
        check("bank_sel", bank_sel, n_gens % 2);
    endtask

    task automatic check_reset_outputs;
        check("rst_calc_flag", calc_flag, 0);
        check("rst_calc_row", calc_row, 0);
        check("rst_bank_sel", bank_sel, 0);
        check("rst_gen_count", gen_count, 0);
        check("rst_gen_done", gen_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
    endtask

    // Entered while observing WAIT_FRAME; leaves while observing the IDLE cycle after SWAP.
    task automatic run_generation;
        int gap, lat, flags;
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            row_done = ($urandom_range(0, 1) == 1);
            step     = ($urandom_range(0, 1) == 1);
            tick();
            row_done = 1'b0;
            step     = 1'b0;
            check("wf_calc_flag", calc_flag, 0);
            check("wf_busy", busy, 1);
        end
        pulse_frame();
        flags = 0;
        for (int r = 0; r < ROWS; r++) begin
            check("issue_flag", calc_flag, 1);
            check("issue_row", calc_row, r);
            if (calc_flag) flags++;
            lat = $urandom_range(1, 5);
            for (int k = 0; k < lat; k++) begin
                step        = ($urandom_range(0, 3) == 0);
                frame_start = ($urandom_range(0, 3) == 0);
                tick();
                step        = 1'b0;
                frame_start = 1'b0;
                check("wait_flag", calc_flag, 0);
                check("wait_row", calc_row, r);
                check("wait_busy", busy, 1);
            end
            row_done = 1'b1;
            tick();
            row_done = 1'b0;
        end
        check("swap_gen_done", gen_done, 1);
        check("swap_busy", busy, 1);
        check("flag_count", flags, ROWS);
        n_gens++;
        tick();
        check("idle_gen_done", gen_done, 0);
        check("idle_busy", busy, 0);
        check("idle_calc_row", calc_row, 0);
        check_totals();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0; mode = 1'b0;
        frame_start = 1'b0; row_done = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) tick();
        rst = 1'b0;

        row_done = 1'b1;
        tick();
        row_done = 1'b0;
        check("stray_rd_busy", busy, 0);
        check("stray_rd_flag", calc_flag, 0);

        // Continuous run: five generations exercise the 2-bit counter wrap.
        run = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("run_wait_frame", busy, 1);
            run_generation();
        end
        run = 1'b0;
        tick();
        check("run_off_idle", busy, 0);

        // Single step: one generation, later frames do nothing.
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_start", busy, 1);
        run_generation();
        for (int i = 0; i < 6; i++) begin
            frame_start = (i == 1 || i == 4);
            tick();
            frame_start = 1'b0;
            check("step_once_busy", busy, 0);
            check("step_once_flag", calc_flag, 0);
        end
        check_totals();

        // Step together with run: run wins, one generation per frame.
        step = 1'b1;
        run  = 1'b1;
        tick();
        step = 1'b0;
        check("runstep_start", busy, 1);
        run_generation();
        for (int g = 0; g < 2; g++) begin
            tick();
            check("runstep_wait", busy, 1);
            run_generation();
        end

        // Mode abort coinciding with row_done of row 1.
        tick();
        check("abort_wf", busy, 1);
        pulse_frame();
        check("abort_row0", calc_row, 0);
        repeat (2) tick();
        row_done = 1'b1;
        tick();
        row_done = 1'b0;
        check("abort_row1", calc_row, 1);
        repeat (2) tick();
        mode     = ~mode;
        row_done = 1'b1;
        tick();
        row_done = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_calc_row", calc_row, 0);
        check("abort_flag", calc_flag, 0);
        check("abort_gen_done", gen_done, 0);
        check_totals();
        tick();
        check("abort_restart", busy, 1);
        check("abort_no_gen_done", gen_done, 0);
        run_generation();

        // Watchdog: withhold row_done after row 2 is issued.
        tick();
        pulse_frame();
        for (int r = 0; r < 2; r++) begin
            repeat (2) tick();
            row_done = 1'b1;
            tick();
            row_done = 1'b0;
        end
        check("to_issue_row", calc_row, 2);
        check("to_issue_flag", calc_flag, 1);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            check("to_err_early", err, 0);
        end
        tick();
        check("to_err", err, 1);
        check("to_calc_row", calc_row, 0);
        check("to_busy", busy, 0);
        check_totals();
        for (int i = 0; i < 8; i++) begin
            step        = (i == 2);
            frame_start = (i == 4);
            tick();
            step        = 1'b0;
            frame_start = 1'b0;
            check("err_lock_busy", busy, 0);
            check("err_sticky", err, 1);
        end

        rst  = 1'b1;
        mode = 1'b0;
        n_gens = 0;
        tick();
        check("rst_clears_err", err, 0);
        rst = 1'b0;

        // Asynchronous reset between edges while a row is outstanding.
        tick();
        check("ar_wf", busy, 1);
        pulse_frame();
        run_generation_skip: begin
            repeat (2) tick();
            check("ar_in_row", busy, 1);
            #2;
            rst = 1'b1;
            #1;
            check_reset_outputs();
        end
        run = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        row_done = 1'b1;
        tick();
        row_done = 1'b0;
        check("ar_stray_busy", busy, 0);
        check("ar_stray_flag", calc_flag, 0);
        tick();
        check("ar_idle_busy", busy, 0);
        check_totals();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed expired expected finish");
        $fatal(1, "bench timeout");
    end
endmodule
